fifo_rd_packer: RTL and testbench

- Read-side consumer for the 8-bit FIFO.
- Drives the FIFO read interface (r_en, r_data, r_empty) and packs successive bytes into 32-bit words.
- Presents each packed word downstream on a valid/ready handshake.
- Supports a flush request that emits a partially filled word with its byte count. Sits in the r_clk domain next to the FIFO's read port.

---
 rtl/fifo_rd_packer.sv | 133 +++++++++++++
 tb/tb_fifo_rd_packer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: packs successive bytes into 32-bit words and
// offers them downstream, with a flush that emits a partial word.
module fifo_rd_packer #(
    parameter int BYTES_PER_WORD = 4,
    parameter int CNT_W          = 16
) (
    input  logic                        r_clk,
    input  logic                        rst,
    input  logic                        r_empty,
    output logic                        r_en,
    input  logic [7:0]                  r_data,
    input  logic                        flush,
    output logic [8*BYTES_PER_WORD-1:0] out_data,
    output logic [2:0]                  out_bytes,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CNT_W-1:0]            byte_total,
    output logic                        o_dbg_state
);

    localparam int W = 8 * BYTES_PER_WORD;

    // Downstream handshake: a word transfers on any rising edge where
    // out_valid=1 and out_ready=1; out_data/out_bytes are frozen while
    // out_valid=1 and out_ready=0, and out_ready is ignored when out_valid=0.
    typedef enum logic {
        S_FILL = 1'b0,
        S_OUT  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_fill;
    logic [2:0]       w_fill_nxt;
    logic             r_rd_pend;
    logic             r_flush_pend;
    logic             w_flush_pend_nxt;
    logic [W-1:0]     r_word;
    logic [W-1:0]     w_word_nxt;
    logic [W-1:0]     r_out_data;
    logic [W-1:0]     w_out_data_nxt;
    logic [2:0]       r_out_bytes;
    logic [2:0]       w_out_bytes_nxt;
    logic             r_out_valid;
    logic             w_out_valid_nxt;
    logic [CNT_W-1:0] r_byte_total;
    logic [CNT_W-1:0] w_byte_total_nxt;
    logic [2:0]       w_fill_sum;
    logic             w_rd_en;
    logic             w_hs;

    // Counting the in-flight byte keeps at most four bytes committed per word.
    assign w_fill_sum = r_fill + {2'b00, r_rd_pend};
    assign w_rd_en    = (r_state == S_FILL) && !r_empty && !r_flush_pend
                        && (w_fill_sum < 3'(BYTES_PER_WORD));
    assign w_hs       = r_out_valid && out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_fill_nxt       = r_fill;
        w_word_nxt       = r_word;
        w_flush_pend_nxt = r_flush_pend | flush;
        w_out_data_nxt   = r_out_data;
        w_out_bytes_nxt  = r_out_bytes;
        w_out_valid_nxt  = r_out_valid;
        w_byte_total_nxt = r_byte_total;
        case (r_state)
            S_FILL: begin
                if (r_rd_pend) begin
                    w_word_nxt[{r_fill[1:0], 3'b000} +: 8] = r_data;
                    w_fill_nxt = r_fill + 3'd1;
                    if (r_fill == 3'(BYTES_PER_WORD - 1)) begin
                        w_state_nxt     = S_OUT;
                        w_out_data_nxt  = w_word_nxt;
                        w_out_bytes_nxt = 3'(BYTES_PER_WORD);
                        w_out_valid_nxt = 1'b1;
                    end
                end else if (r_flush_pend) begin
                    // A pulse landing on the service edge stays pending.
                    w_flush_pend_nxt = flush;
                    if (r_fill != 3'd0) begin
                        w_state_nxt     = S_OUT;
                        w_out_data_nxt  = r_word;
                        w_out_bytes_nxt = r_fill;
                        w_out_valid_nxt = 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (w_hs) begin
                    w_out_valid_nxt  = 1'b0;
                    w_byte_total_nxt = r_byte_total + CNT_W'(r_out_bytes);
                    w_fill_nxt       = 3'd0;
                    w_word_nxt       = '0;
                    w_state_nxt      = S_FILL;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge r_clk) begin
        if (rst) begin
            r_state      <= S_FILL;
            r_fill       <= 3'd0;
            r_rd_pend    <= 1'b0;
            r_flush_pend <= 1'b0;
            r_word       <= '0;
            r_out_data   <= '0;
            r_out_bytes  <= 3'd0;
            r_out_valid  <= 1'b0;
            r_byte_total <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_fill       <= w_fill_nxt;
            r_rd_pend    <= w_rd_en;
            r_flush_pend <= w_flush_pend_nxt;
            r_word       <= w_word_nxt;
            r_out_data   <= w_out_data_nxt;
            r_out_bytes  <= w_out_bytes_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_byte_total <= w_byte_total_nxt;
        end
    end

    assign r_en        = w_rd_en;
    assign out_data    = r_out_data;
    assign out_bytes   = r_out_bytes;
    assign out_valid   = r_out_valid;
    assign byte_total  = r_byte_total;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a queue-backed FIFO model feeds bytes, and a
// byte-stream model predicts every packed word and the running byte total.
module tb_fifo_rd_packer;

    logic        r_clk = 1'b0;
    logic        rst;
    logic        r_empty;
    logic        r_en;
    logic [7:0]  r_data;
    logic        flush;
    logic [31:0] out_data;
    logic [2:0]  out_bytes;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] byte_total;
    logic        dbg_state;

    int checks;
    int errors;

    // FIFO model: bytes written by the driver, read one cycle after r_en.
    logic [7:0]  mem [0:1023];
    int unsigned n_push;
    int unsigned n_pop = 0;

    // Reference model: bytes not yet grouped, expected {bytes, data} words.
    logic [7:0]  model_buf [$];
    logic [34:0] exp_q [$];
    logic [15:0] model_total;

    always #5 r_clk = ~r_clk;

    assign r_empty = (n_push == n_pop);

    always @(posedge r_clk) begin
        if (r_en) begin
            r_data <= mem[n_pop % 1024];
            n_pop  <= n_pop + 1;
        end
    end

    fifo_rd_packer #(
        .BYTES_PER_WORD(4),
        .CNT_W(16)
    ) dut (
        .r_clk(r_clk),
        .rst(rst),
        .r_empty(r_empty),
        .r_en(r_en),
        .r_data(r_data),
        .flush(flush),
        .out_data(out_data),
        .out_bytes(out_bytes),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .byte_total(byte_total),
        .o_dbg_state(dbg_state)
    );

    task automatic push_raw(input logic [7:0] b);
        mem[n_push % 1024] = b;
        n_push = n_push + 1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        push_raw(b);
        model_buf.push_back(b);
        if (model_buf.size() == 4) begin
            exp_q.push_back({3'd4, model_buf[3], model_buf[2], model_buf[1], model_buf[0]});
            model_buf.delete();
        end
    endtask

    task automatic flush_model();
        logic [31:0] w;
        w = 32'h0;
        if (model_buf.size() > 0) begin
            for (int i = 0; i < model_buf.size(); i++) w[8*i +: 8] = model_buf[i];
            exp_q.push_back({3'(model_buf.size()), w});
            model_buf.delete();
        end
    endtask

    task automatic pulse_flush();
        @(negedge r_clk);
        flush = 1'b1;
        flush_model();
        @(negedge r_clk);
        flush = 1'b0;
    endtask

    // Wait until the FIFO is drained and every predicted word has left.
    task automatic settle();
        int n;
        n = 0;
        while (!(n_push == n_pop && exp_q.size() == 0 && out_valid == 1'b0) && n < 300) begin
            @(negedge r_clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL settle_timeout: pending_words=%0d out_valid=%b, required drain within 300 cycles",
                     exp_q.size(), out_valid);
        end
        repeat (3) @(negedge r_clk);
    endtask

    task automatic monitor();
        logic        prev_hold;
        logic [31:0] prev_data;
        logic [2:0]  prev_bytes;
        logic [34:0] e;
        prev_hold  = 1'b0;
        prev_data  = 32'h0;
        prev_bytes = 3'd0;
        forever begin
            @(negedge r_clk);
            #1;
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (out_valid) begin
                    checks++;
                    if (r_en !== 1'b0) begin
                        errors++;
                        $display("FAIL r_en_while_holding: r_en=%b required 0", r_en);
                    end
                end
                if (prev_hold) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== prev_data || out_bytes !== prev_bytes) begin
                        errors++;
                        $display("FAIL hold_stable: valid=%b data=%h bytes=%0d required 1 %h %0d",
                                 out_valid, out_data, out_bytes, prev_data, prev_bytes);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_word: data=%h bytes=%0d required no word", out_data, out_bytes);
                    end else begin
                        e = exp_q.pop_front();
                        model_total = model_total + 16'(e[34:32]);
                        if ({out_bytes, out_data} !== e) begin
                            errors++;
                            $display("FAIL word: data=%h bytes=%0d required %h %0d",
                                     out_data, out_bytes, e[31:0], e[34:32]);
                        end
                    end
                end
                prev_hold  = out_valid && !out_ready;
                prev_data  = out_data;
                prev_bytes = out_bytes;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge r_clk);
        checks++;
        if ({r_en, out_valid, out_data, out_bytes, byte_total} !== 53'h0) begin
            errors++;
            $display("FAIL reset_outputs: r_en=%b valid=%b data=%h bytes=%0d total=%h required all 0",
                     r_en, out_valid, out_data, out_bytes, byte_total);
        end
        rst = 1'b0;
        @(negedge r_clk);
    endtask

    task automatic test_basic();
        int n;
        out_ready = 1'b1;
        @(negedge r_clk);
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        #1;
        checks++;
        if (r_en !== 1'b1) begin
            errors++;
            $display("FAIL basic_first_ren: r_en=%b required 1", r_en);
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge r_clk);
            n++;
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL basic_latency: cycles=%0d required 5", n);
        end
        checks++;
        if (out_data !== 32'h44332211 || out_bytes !== 3'd4) begin
            errors++;
            $display("FAIL basic_word: data=%h bytes=%0d required 44332211 4", out_data, out_bytes);
        end
        @(negedge r_clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_single_valid: out_valid=%b required 0", out_valid);
        end
        checks++;
        if (byte_total !== 16'd4) begin
            errors++;
            $display("FAIL basic_total: byte_total=%0d required 4", byte_total);
        end
        settle();
    endtask

    task automatic test_stall();
        int n;
        out_ready = 1'b0;
        @(negedge r_clk);
        for (int i = 1; i <= 8; i++) push_byte(8'(i));
        n = 0;
        while (out_valid !== 1'b1 && n < 30) begin
            @(negedge r_clk);
            n++;
        end
        repeat (10) begin
            @(negedge r_clk);
            checks++;
            if (r_en !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h04030201) begin
                errors++;
                $display("FAIL stall_hold: r_en=%b valid=%b data=%h required 0 1 04030201",
                         r_en, out_valid, out_data);
            end
        end
        out_ready = 1'b1;
        settle();
        checks++;
        if (byte_total !== model_total) begin
            errors++;
            $display("FAIL stall_total: byte_total=%0d required %0d", byte_total, model_total);
        end
    endtask

    task automatic test_flush_partial();
        int n;
        out_ready = 1'b0;
        @(negedge r_clk);
        push_byte(8'hAA);
        push_byte(8'hBB);
        settle();
        pulse_flush();
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge r_clk);
            n++;
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000BBAA || out_bytes !== 3'd2) begin
            errors++;
            $display("FAIL flush_partial_word: valid=%b data=%h bytes=%0d required 1 0000bbaa 2",
                     out_valid, out_data, out_bytes);
        end
        push_byte(8'hCC);
        repeat (5) begin
            @(negedge r_clk);
            checks++;
            if (r_en !== 1'b0) begin
                errors++;
                $display("FAIL flush_blocks_read: r_en=%b required 0", r_en);
            end
        end
        out_ready = 1'b1;
        settle();
        pulse_flush();
        settle();
        checks++;
        if (byte_total !== model_total) begin
            errors++;
            $display("FAIL flush_total: byte_total=%0d required %0d", byte_total, model_total);
        end
    endtask

    task automatic test_flush_empty();
        logic [15:0] saved;
        saved = model_total;
        pulse_flush();
        repeat (20) begin
            @(negedge r_clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_empty_valid: out_valid=%b required 0", out_valid);
            end
        end
        checks++;
        if (byte_total !== saved) begin
            errors++;
            $display("FAIL flush_empty_total: byte_total=%0d required %0d", byte_total, saved);
        end
    endtask

    task automatic test_rst_mid();
        out_ready = 1'b1;
        @(negedge r_clk);
        for (int i = 0; i < 4; i++) push_raw(8'($urandom_range(0, 255)));
        // Four cycles later three bytes are held and the fourth is in flight.
        repeat (4) @(negedge r_clk);
        rst = 1'b1;
        @(negedge r_clk);
        rst = 1'b0;
        exp_q.delete();
        model_buf.delete();
        model_total = 16'h0;
        checks++;
        if ({r_en, out_valid, out_data, out_bytes, byte_total} !== 53'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: r_en=%b valid=%b data=%h bytes=%0d total=%h required all 0",
                     r_en, out_valid, out_data, out_bytes, byte_total);
        end
        for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(0, 255)));
        settle();
        checks++;
        if (byte_total !== 16'd4) begin
            errors++;
            $display("FAIL rst_mid_total: byte_total=%0d required 4", byte_total);
        end
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        @(negedge r_clk);
        force dut.r_byte_total = 16'hFFFC;
        @(negedge r_clk);
        release dut.r_byte_total;
        model_total = 16'hFFFC;
        @(negedge r_clk);
        checks++;
        if (byte_total !== 16'hFFFC) begin
            errors++;
            $display("FAIL wrap_preload: byte_total=%h required fffc", byte_total);
        end
        for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(0, 255)));
        settle();
        checks++;
        if (byte_total !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_total: byte_total=%h required 0000", byte_total);
        end
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(5, 30);
            for (int i = 0; i < n; i++) begin
                @(negedge r_clk);
                out_ready = 1'($urandom_range(0, 1));
                push_byte(8'($urandom_range(0, 255)));
                repeat ($urandom_range(0, 2)) begin
                    @(negedge r_clk);
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
            out_ready = 1'b1;
            settle();
            pulse_flush();
            settle();
            checks++;
            if (byte_total !== model_total) begin
                errors++;
                $display("FAIL random_total: round=%0d byte_total=%0d required %0d", r, byte_total, model_total);
            end
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        n_push      = 0;
        model_total = 16'h0;
        rst         = 1'b1;
        flush       = 1'b0;
        out_ready   = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_stall();
        test_flush_partial();
        test_flush_empty();
        test_rst_mid();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
